// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: constants and helpers shared by the mem_io_responder slice.
//   - Controller-side macros for bus direction and field ranges.
//   - IO window select and register offsets.
//   - Access-kind enum plus a decode helper so the top stays a flat case.
// No ports; imported with import mem_io_responder_pkg::*.

`ifndef MEM_IO_RESPONDER_DEFS_SVH
`define MEM_IO_RESPONDER_DEFS_SVH
`define READ           1'b0
`define WRITE          1'b1
`define RAM_DATA_RANGE 7:0
`define WORD_RANGE     31:0
`endif

package mem_io_responder_pkg;

    // IO window lives where address[17:16] == 2'b11 (0x30000..0x3FFFF).
    localparam logic [1:0] IO_BASE_SEL = 2'b11;
    localparam logic [2:0] IO_DATA_OFF = 3'd0;
    localparam logic [2:0] IO_STAT_OFF = 3'd4;

    typedef enum logic [2:0] {
        AccRamRd,   // RAM byte read
        AccRamWr,   // RAM byte write
        AccTxPush,  // write to data register: enqueue for the UART
        AccHalt,    // write to status register: set program_finish
        AccRxPop,   // read of data register: dequeue received byte
        AccStatRd,  // read of status register
        AccIoNop,   // write to an unmapped IO offset
        AccIoZero   // read of an unmapped IO offset
    } access_e;

    function automatic access_e decode_access(input logic wr, input logic [`WORD_RANGE] addr);
        access_e acc;
        if (addr[17:16] != IO_BASE_SEL) begin
            acc = (wr == `WRITE) ? AccRamWr : AccRamRd;
        end else if (wr == `WRITE) begin
            if (addr[2:0] == IO_DATA_OFF) begin
                acc = AccTxPush;
            end else if (addr[2:0] == IO_STAT_OFF) begin
                acc = AccHalt;
            end else begin
                acc = AccIoNop;
            end
        end else begin
            if (addr[2:0] == IO_DATA_OFF) begin
                acc = AccRxPop;
            end else if (addr[2:0] == IO_STAT_OFF) begin
                acc = AccStatRd;
            end else begin
                acc = AccIoZero;
            end
        end
        return acc;
    endfunction

    // Status register layout: bit1 = RX data waiting, bit0 = TX FIFO full.
    function automatic logic [`RAM_DATA_RANGE] status_byte(input logic rx_nonempty,
                                                           input logic tx_full);
        return {6'b0, rx_nonempty, tx_full};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO with 2^DEPTH_LOG entries and a combinational head.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears pointers and count)
//   push, push_data  enqueue request and byte
//   pop              dequeue request (ignored while empty)
//   head_data        byte at the read pointer
//   full, empty      occupancy flags
//   count            current occupancy, 0..2^DEPTH_LOG
// A push while full is dropped unless a pop happens in the same cycle.

module byte_fifo #(
    parameter int unsigned DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [7:0]           push_data,
    input  logic                 pop,
    output logic [7:0]           head_data,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;
    localparam int unsigned CntW  = DEPTH_LOG + 1;
    localparam logic [DEPTH_LOG-1:0] PtrOne = 1;

    logic [7:0]           mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG:0]   count_q;
    logic                 pop_ok, push_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side end of the controller's byte-wide RAM port.
//   RAM bytes are returned with one cycle of read latency; the IO window
//   (address[17:16] == 2'b11) maps a UART TX FIFO, an RX path and a halt flag.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_wr            1 = write, 0 = read
//   mem_addr          byte address
//   mem_din           write byte
//   mem_dout          registered read byte
//   io_buffer_full    TX FIFO near-full, gates store issue upstream
//   tx_data/valid     head of TX FIFO toward the UART; tx_ready pops it
//   rx_data/valid     byte from the UART receiver; rx_ready = room available
//   program_finish    sticky halt flag
// Build option: define IO_RX_EN to instantiate the RX FIFO; otherwise rx_ready
// is 0 and data-register reads return 0.

module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH_LOG   = 3,
    parameter int unsigned RX_DEPTH_LOG   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_finish
);

    localparam int unsigned RamDepth = 1 << RAM_ADDR_WIDTH;
    localparam int unsigned TxDepth  = 1 << TX_DEPTH_LOG;
    localparam int unsigned TxCntW   = TX_DEPTH_LOG + 1;

    access_e                   acc;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic [`RAM_DATA_RANGE]    ram_q [RamDepth];

    logic [`RAM_DATA_RANGE]    mem_dout_q, mem_dout_d;
    logic                      finish_q, finish_d;
    logic                      ibf_q;
    logic                      ram_we, tx_push, rx_pop;

    logic                      tx_full, tx_empty, tx_pop;
    logic [TX_DEPTH_LOG:0]     tx_count, tx_count_next;
    logic                      tx_push_ok, tx_pop_ok;

    logic [7:0]                rx_head;
    logic                      rx_empty;

    assign acc     = decode_access(mem_wr, mem_addr);
    assign ram_idx = mem_addr[RAM_ADDR_WIDTH-1:0];

    // Writes presented while rst is high are dropped everywhere.
    always_comb begin
        ram_we     = 1'b0;
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        finish_d   = finish_q;
        mem_dout_d = mem_dout_q;
        unique case (acc)
            AccRamRd:  mem_dout_d = ram_q[ram_idx];
            AccRamWr:  ram_we     = !rst;
            AccTxPush: tx_push    = !rst;
            AccHalt:   finish_d   = 1'b1;
            AccRxPop: begin
                rx_pop     = 1'b1;
                mem_dout_d = rx_empty ? 8'h00 : rx_head;
            end
            AccStatRd: mem_dout_d = status_byte(!rx_empty, tx_full);
            AccIoNop:  ;
            AccIoZero: mem_dout_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= mem_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_dout_q <= 8'h00;
            finish_q   <= 1'b0;
            ibf_q      <= 1'b0;
        end else begin
            mem_dout_q <= mem_dout_d;
            finish_q   <= finish_d;
            ibf_q      <= (tx_count_next >= TxCntW'(TxDepth - 2));
        end
    end

    assign mem_dout       = mem_dout_q;
    assign program_finish = finish_q;
    assign io_buffer_full = ibf_q;

    // ---------------------------------------------------------------- TX path
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;

    byte_fifo #(
        .DEPTH_LOG (TX_DEPTH_LOG)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (mem_din),
        .pop       (tx_pop),
        .head_data (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    // Occupancy after this edge; the flag leads the real full by two entries so a
    // store already in flight when the flag rises still fits.
    assign tx_pop_ok     = tx_pop;
    assign tx_push_ok    = tx_push && (!tx_full || tx_pop_ok);
    assign tx_count_next = tx_count + TxCntW'(tx_push_ok) - TxCntW'(tx_pop_ok);

    // ---------------------------------------------------------------- RX path
`ifdef IO_RX_EN
    logic                  rx_full;
    logic [RX_DEPTH_LOG:0] rx_count;
    logic                  unused_rx_count;

    assign rx_ready = !rx_full;

    byte_fifo #(
        .DEPTH_LOG (RX_DEPTH_LOG)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid && rx_ready && !rst),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head_data (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign unused_rx_count = ^rx_count;
`else
    logic        unused_rx;
    logic [31:0] unused_rx_cfg;

    assign rx_ready      = 1'b0;
    assign rx_empty      = 1'b1;
    assign rx_head       = 8'h00;
    assign unused_rx     = ^{rx_data, rx_valid, rx_pop};
    assign unused_rx_cfg = RX_DEPTH_LOG;
`endif

    // Address bits above the RAM index and IO select are don't-care.
    logic unused_addr;
    assign unused_addr = ^mem_addr;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed self-checking bench for mem_io_responder.
// Read expectations go through a scoreboard queue; TX/RX/halt state is tracked by
// small bench-side models and every cycle's outputs are compared against them.

module tb_mem_io_responder;

`ifdef IO_RX_EN
    localparam bit RxEn = 1'b1;
`else
    localparam bit RxEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_finish;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_model[$];
    logic [7:0] rx_model[$];
    bit         halt_m = 1'b0;

    always #5 clk = ~clk;

    mem_io_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .program_finish (program_finish)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // One bus cycle; models advance with the clock edge, outputs sampled 1ns later.
    task automatic cyc(input logic wr, input logic [31:0] a, input logic [7:0] d);
        bit is_io, t_pop, t_push, r_pop, r_push, h_set;
        mem_wr = wr; mem_addr = a; mem_din = d;
        is_io  = (a[17:16] == 2'b11);
        t_pop  = (tx_model.size() != 0) && tx_ready;
        t_push = !rst && wr && is_io && (a[2:0] == 3'd0) && (tx_model.size() < 8 || t_pop);
        r_pop  = !wr && is_io && (a[2:0] == 3'd0) && (rx_model.size() != 0);
        r_push = RxEn && !rst && rx_valid && (rx_model.size() < 8);
        h_set  = !rst && wr && is_io && (a[2:0] == 3'd4);
        @(posedge clk);
        #1;
        if (rst) begin
            tx_model.delete();
            rx_model.delete();
            halt_m = 1'b0;
        end else begin
            if (t_pop)  void'(tx_model.pop_front());
            if (t_push) tx_model.push_back(d);
            if (r_pop)  void'(rx_model.pop_front());
            if (r_push) rx_model.push_back(rx_data);
            if (h_set)  halt_m = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/tx_valid"}, 8'(tx_valid), 8'(tx_model.size() != 0));
        if (tx_model.size() != 0) check({tag, "/tx_data"}, tx_data, tx_model[0]);
        check({tag, "/io_buffer_full"}, 8'(io_buffer_full), 8'(tx_model.size() >= 6));
        check({tag, "/program_finish"}, 8'(program_finish), 8'(halt_m));
        check({tag, "/rx_ready"}, 8'(rx_ready), 8'(RxEn && rx_model.size() < 8));
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [7:0] d);
        cyc(1'b1, a, d);
        check_outputs(tag);
    endtask

    // Scoreboarded read: expectation queued when the address is driven.
    task automatic rd(input string tag, input logic [31:0] a, input logic [7:0] exp);
        exp_q.push_back(exp);
        cyc(1'b0, a, 8'h00);
        check(tag, mem_dout, exp_q.pop_front());
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 32'h0, 8'h00);
        check_outputs(tag);
    endtask

    function automatic logic [7:0] stat_exp();
        return {6'b0, rx_model.size() != 0, tx_model.size() == 8};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] last;
        int         n;

        rst = 1'b1; mem_wr = 1'b0; mem_addr = '0; mem_din = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        cyc(1'b0, 32'h0, 8'h00);
        cyc(1'b0, 32'h0, 8'h00);
        check("reset/mem_dout", mem_dout, 8'h00);
        check_outputs("reset");
        check("reset/rx_ready_const", 8'(rx_ready), RxEn ? 8'h01 : 8'h00);
        rst = 1'b0;

        // RAM write/read, hold during write, upper-bit aliasing, top byte.
        wr("ram_wr", 32'h0000_0100, 8'hA5);
        rd("ram_rd", 32'h0000_0100, 8'hA5);
        wr("ram_wr2", 32'h0000_0200, 8'h55);
        check("ram_hold_on_write", mem_dout, 8'hA5);
        rd("ram_rd_after_wr", 32'h0000_0100, 8'hA5);
        rd("ram_rd2", 32'h0000_0200, 8'h55);
        rd("ram_alias_hi", 32'hFFFC_0100, 8'hA5);
        rd("ram_alias_b17", 32'h0002_0100, 8'hA5);
        wr("ram_wr_top", 32'h0001_FFFF, 8'h3C);
        rd("ram_rd_top", 32'h0001_FFFF, 8'h3C);

        // Unmapped IO offsets.
        wr("io_nop_wr", 32'h0003_0002, 8'h77);
        rd("io_nop_rd2", 32'h0003_0002, 8'h00);
        rd("io_nop_rd6", 32'h0003_0006, 8'h00);
        rd("stat_empty", 32'h0003_0004, stat_exp());

        // Fill TX with tx_ready low; 9th push dropped.
        for (int i = 0; i < 9; i++) begin
            wr("tx_fill", 32'h0003_0000, 8'h10 + 8'(i));
            if (i == 4) check("ibf_after_5", 8'(io_buffer_full), 8'h00);
            if (i == 5) check("ibf_after_6", 8'(io_buffer_full), 8'h01);
        end
        rd("stat_tx_full", 32'h0003_0004, 8'h01);

        // Push and pop together on a full FIFO.
        tx_ready = 1'b1;
        wr("tx_full_push_pop", 32'h0003_0000, 8'h99);
        check("tx_head_after_pp", tx_data, 8'h11);
        check("ibf_full_pp", 8'(io_buffer_full), 8'h01);
        n = 0; last = 8'h00;
        for (int k = 0; k < 10; k++) begin
            if (tx_valid) begin
                n++;
                last = tx_data;
            end
            idle("tx_drain");
        end
        check("tx_drain_count", 8'(n), 8'd8);
        check("tx_drain_last", last, 8'h99);
        check("tx_drained_valid", 8'(tx_valid), 8'h00);

        // Two-byte drain.
        tx_ready = 1'b0;
        wr("tx_41", 32'h0003_0000, 8'h41);
        wr("tx_42", 32'h0003_0000, 8'h42);
        check("tx_head_41", tx_data, 8'h41);
        tx_ready = 1'b1;
        idle("tx_pop_41");
        check("tx_head_42", tx_data, 8'h42);
        idle("tx_pop_42");
        check("tx_empty_valid", 8'(tx_valid), 8'h00);

        // Push and pop together on an empty FIFO: only the push happens.
        wr("tx_empty_push_pop", 32'h0003_0000, 8'h77);
        check("tx_empty_pp_valid", 8'(tx_valid), 8'h01);
        check("tx_empty_pp_data", tx_data, 8'h77);
        idle("tx_pop_77");

        // Halt is sticky; reset clears it, flushes TX and ignores writes.
        tx_ready = 1'b0;
        wr("halt", 32'h0003_0004, 8'h00);
        check("halt_set", 8'(program_finish), 8'h01);
        idle("halt_hold1");
        idle("halt_hold2");
        check("halt_sticky", 8'(program_finish), 8'h01);
        wr("ram_wr_300", 32'h0000_0300, 8'h11);
        for (int i = 0; i < 6; i++) wr("tx_prefill", 32'h0003_0000, 8'h60 + 8'(i));
        check("ibf_before_rst", 8'(io_buffer_full), 8'h01);
        rst = 1'b1;
        wr("rst_tx_wr", 32'h0003_0000, 8'hEE);
        wr("rst_ram_wr", 32'h0000_0300, 8'h22);
        wr("rst_halt_wr", 32'h0003_0004, 8'h00);
        rst = 1'b0;
        check("rst_pf", 8'(program_finish), 8'h00);
        check("rst_tx_valid", 8'(tx_valid), 8'h00);
        check("rst_ibf", 8'(io_buffer_full), 8'h00);
        check("rst_dout", mem_dout, 8'h00);
        rd("rst_ram_wr_ignored", 32'h0000_0300, 8'h11);

        // RX path: one byte, status, pop, pop-empty.
        rx_valid = 1'b1; rx_data = 8'h5A;
        idle("rx_push");
        rx_valid = 1'b0;
        rd("rx_stat", 32'h0003_0004, RxEn ? 8'h02 : 8'h00);
        rd("rx_pop1", 32'h0003_0000, RxEn ? 8'h5A : 8'h00);
        rd("rx_pop2", 32'h0003_0000, 8'h00);

        // RX fill past capacity, then a simultaneous push and pop, then drain.
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h80 + 8'(i);
            idle("rx_fill");
        end
        rx_valid = 1'b0;
        check("rx_full_ready", 8'(rx_ready), 8'h00);
        rd("rx_pop_full", 32'h0003_0000, (rx_model.size() != 0) ? rx_model[0] : 8'h00);
        rx_valid = 1'b1; rx_data = 8'hC3;
        rd("rx_push_and_pop", 32'h0003_0000, (rx_model.size() != 0) ? rx_model[0] : 8'h00);
        rx_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rd("rx_drain", 32'h0003_0000, (rx_model.size() != 0) ? rx_model[0] : 8'h00);
        end
        rd("rx_stat_end", 32'h0003_0004, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
